audio_tone_generator: RTL

Parametrised multi-channel test-tone source; successor to the single-channel fixed sine generator used for ADAU bring-up. Each channel runs its own phase accumulator with a runtime-selectable waveform (silence/sine/square/sawtooth), frequency and attenuation. A single shared sine ROM is time-multiplexed across channels by a sequencing FSM. Completed frames go out over a valid/ready handshake to adau_interface or a FIFO.

---
 rtl/audio_tone_generator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/audio_tone_generator.sv
// Multi-channel test-tone source: per-channel phase accumulators
// sharing one sine ROM, frames delivered over valid/ready.
module audio_tone_generator #(
   parameter int NUM_CHANNELS  = 2,
   parameter int SAMPLE_WIDTH  = 24,
   parameter int PHASE_WIDTH   = 32,
   parameter int LUT_ADDR_BITS = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [NUM_CHANNELS*PHASE_WIDTH-1:0]  phase_inc,
   input  logic [NUM_CHANNELS*2-1:0]            mode,
   input  logic [NUM_CHANNELS*4-1:0]            atten,
   output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam int DEPTH = 2 ** LUT_ADDR_BITS;
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic signed [SAMPLE_WIDTH-1:0] MAX_S =
      {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC_ADDR,
      CALC_DATA,
      PRESENT
   } state_t;

   function automatic logic [SAMPLE_WIDTH-1:0] sine_entry(input int k);
      real    pi;
      real    amp;
      real    v;
      longint r;
      pi  = 3.14159265358979323846;
      amp = (2.0 ** (SAMPLE_WIDTH - 1)) - 1.0;
      v   = amp * $sin(2.0 * pi * real'(k) / real'(DEPTH));
      r   = longint'(v);
      return r[SAMPLE_WIDTH-1:0];
   endfunction

   logic [SAMPLE_WIDTH-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      assign rom[k] = sine_entry(k);
   end

   state_t                  state_q, state_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic [PHASE_WIDTH-1:0]  phase_q [NUM_CHANNELS];
   logic [PHASE_WIDTH-1:0]  phase_d [NUM_CHANNELS];
   logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] frame_q, frame_d;
   logic [SAMPLE_WIDTH-1:0] rom_q, rom_d;

   logic [LUT_ADDR_BITS-1:0]       rom_addr;
   logic [SAMPLE_WIDTH-1:0]        phase_top;
   logic [1:0]                     cur_mode;
   logic [3:0]                     cur_atten;
   logic signed [SAMPLE_WIDTH-1:0] wave;
   logic signed [SAMPLE_WIDTH-1:0] scaled;

   assign rom_addr  = phase_q[ch_q][PHASE_WIDTH-1 -: LUT_ADDR_BITS];
   assign phase_top = phase_q[ch_q][PHASE_WIDTH-1 -: SAMPLE_WIDTH];
   assign cur_mode  = mode[ch_q*2 +: 2];
   assign cur_atten = atten[ch_q*4 +: 4];
   assign out_data  = frame_q;

   // ROM data lands one cycle after CALC_ADDR presents the address
   always_comb begin
      rom_d = rom_q;
      if (state_q == CALC_ADDR) begin
         rom_d = rom[rom_addr];
      end
   end

   always_comb begin
      wave = '0;
      unique case (cur_mode)
         2'd0: wave = '0;
         2'd1: wave = rom_q;
         2'd2: wave = phase_top[SAMPLE_WIDTH-1] ? -MAX_S : MAX_S;
         default: wave = {~phase_top[SAMPLE_WIDTH-1],
                          phase_top[SAMPLE_WIDTH-2:0]};
      endcase
      scaled = wave >>> cur_atten;
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      frame_d   = frame_q;
      phase_d   = phase_q;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = CALC_ADDR;
               ch_d    = '0;
            end
         end
         CALC_ADDR: begin
            state_d = CALC_DATA;
         end
         CALC_DATA: begin
            frame_d[ch_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = scaled;
            if (ch_q == CW'(NUM_CHANNELS - 1)) begin
               state_d = PRESENT;
            end else begin
               ch_d    = ch_q + 1'b1;
               state_d = CALC_ADDR;
            end
         end
         PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  phase_d[i] = phase_q[i] +
                               phase_inc[i*PHASE_WIDTH +: PHASE_WIDTH];
               end
               ch_d    = '0;
               state_d = enable ? CALC_ADDR : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         frame_q <= '0;
         rom_q   <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            phase_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         frame_q <= frame_d;
         rom_q   <= rom_d;
         phase_q <= phase_d;
      end
   end

endmodule
